test_pattern_filter: RTL and testbench
======================================

TEST_PATTERN_FILTER -- requirements
Module: test_pattern_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload tdata width in bits.
REQ-002 SHALL have parameter ETH_TYPE, default 16'h88B5, EtherType accepted as test traffic.
REQ-003 SHALL have ports: clk input 1, sole clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have ports: enable input 1, frame forwarding allowed; accept_bcast input 1, also pass dest MAC FF:FF:FF:FF:FF:FF; local_mac input 48, station MAC matched against dest MAC.
REQ-005 SHALL have slave header ports: s_eth_hdr_valid input 1; s_eth_hdr_ready output 1; s_eth_dest_mac input 48; s_eth_src_mac input 48; s_eth_type input 16.
REQ-006 SHALL have slave payload ports: s_eth_payload_axis_tdata input DATA_WIDTH; _tvalid input 1; _tready output 1; _tlast input 1; _tuser input 1.
REQ-007 SHALL have master header ports m_eth_hdr_valid/ready, m_eth_dest_mac, m_eth_src_mac, m_eth_type, and master payload ports m_eth_payload_axis_tdata/tvalid/tready/tlast/tuser, mirroring the slave widths with opposite directions.
REQ-008 SHALL have status outputs frames_passed 32, frames_dropped 32, frames_bad 32 (counters), busy 1 (state != IDLE).

Function
REQ-009 SHALL implement states IDLE, HDR, PASS, DROP.
REQ-010 IDLE: s_eth_hdr_ready=1, s_eth_payload_axis_tready=0, m_eth_hdr_valid=0, m_eth_payload_axis_tvalid=0.
REQ-011 On header accept (valid&&ready in IDLE), SHALL register dest/src/type into output header registers in the same edge.
REQ-012 Match = enable && type==ETH_TYPE && (dest==local_mac || (accept_bcast && dest==48'hFFFFFFFFFFFF)), evaluated on the accepted header values.
REQ-013 Match -> HDR; no match -> DROP; transition on the accept edge.
REQ-014 HDR: m_eth_hdr_valid=1, outputs held stable, s_eth_hdr_ready=0, payload tready=0; on m_eth_hdr_ready -> PASS.
REQ-015 PASS: payload combinational pass-through, zero latency: m tdata/tlast/tuser = s values, m_tvalid=s_tvalid, s_tready=m_tready.
REQ-016 DROP: s_eth_payload_axis_tready=1, m_eth_payload_axis_tvalid=0; beats discarded.
REQ-017 PASS or DROP: on beat accepted with tlast=1 -> IDLE next cycle; header not accepted in that same cycle.
REQ-018 frames_passed +1 on tlast beat in PASS; frames_dropped +1 on tlast beat in DROP; frames_bad +1 on any tlast beat with tuser=1 (in addition to passed/dropped).
REQ-019 Counters SHALL wrap modulo 2^32.
REQ-020 enable, local_mac, accept_bcast sampled only at header accept; changes mid-frame SHALL not affect current frame.
REQ-021 Single-beat frame (first beat tlast=1) SHALL count and return to IDLE like any frame.
REQ-022 Back-pressure in PASS (m_tready=0) SHALL stall upstream with no beat lost or duplicated.

Reset
REQ-023 rst SHALL force state IDLE, all counters 0, m_eth_hdr_valid 0, header registers 0, busy 0, in any state including mid-frame.
REQ-024 Upstream source shares rst; no frame resynchronisation after reset is required.

Verification
REQ-025 Header dest=local_mac=02:00:00:00:00:01, type 88B5, 64-beat payload 0..63 -> identical 64 beats out, tlast on beat 63, frames_passed=1.
REQ-026 Same frame with type 0800 -> no m_eth_hdr_valid, 64 beats sunk at 1/cycle, frames_dropped=1, frames_passed=0.
REQ-027 Broadcast dest with accept_bcast=0 -> dropped; accept_bcast=1 -> passed.
REQ-028 Matching frame, m_eth_hdr_ready held 0 for 5 cycles then 1, m_tready toggled 1/0 each cycle -> header stable while waiting, all 64 beats delivered in order.
REQ-029 Matching frame, tlast beat with tuser=1 -> tuser forwarded, frames_passed=1, frames_bad=1.
REQ-030 rst asserted at beat 20 of a PASS frame -> next cycle state IDLE, counters 0, s_eth_hdr_ready=1; next matching frame passes normally.

Source files
------------

// File: rtl/test_pattern_filter_if.sv
// Ethernet header + AXI-stream payload bundle shared by the filter's upstream and downstream sides.
interface test_pattern_filter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  hdr_valid;
   logic                  hdr_ready;
   logic [47:0]           dest_mac;
   logic [47:0]           src_mac;
   logic [15:0]           eth_type;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (
      output hdr_valid, dest_mac, src_mac, eth_type, tdata, tvalid, tlast, tuser,
      input  hdr_ready, tready
   );

   modport slave (
      input  hdr_valid, dest_mac, src_mac, eth_type, tdata, tvalid, tlast, tuser,
      output hdr_ready, tready
   );
endinterface

// File: rtl/test_pattern_filter.sv
// Forwards test-traffic frames addressed to this station (or broadcast, if allowed) and sinks the rest,
// counting passed, dropped and errored frames.
module test_pattern_filter #(
   parameter int          DATA_WIDTH = 8,
   parameter logic [15:0] ETH_TYPE   = 16'h88B5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         accept_bcast,
   input  logic [47:0]                  local_mac,
   test_pattern_filter_if.slave         s_eth,
   test_pattern_filter_if.master        m_eth,
   output logic [31:0]                  frames_passed,
   output logic [31:0]                  frames_dropped,
   output logic [31:0]                  frames_bad,
   output logic                         busy
);

   typedef enum logic [1:0] {IDLE, HDR, PASS, DROP} state_t;

   state_t                state;
   logic                  hdr_valid_q;
   logic [47:0]           dest_q;
   logic [47:0]           src_q;
   logic [15:0]           type_q;
   logic                  match;
   logic                  hdr_ready;
   logic                  s_tready;
   logic                  m_tvalid;
   logic                  beat;
   logic [DATA_WIDTH-1:0] pass_data;

   // Filter settings are only consulted here, on the accepting edge.
   assign match = enable && (s_eth.eth_type == ETH_TYPE) &&
                  ((s_eth.dest_mac == local_mac) ||
                   (accept_bcast && (s_eth.dest_mac == 48'hFFFF_FFFF_FFFF)));

   always_comb begin
      hdr_ready = (state == IDLE);
      s_tready  = 1'b0;
      m_tvalid  = 1'b0;
      case (state)
         PASS: begin
            s_tready = m_eth.tready;
            m_tvalid = s_eth.tvalid;
         end
         DROP: s_tready = 1'b1;
         default: ;
      endcase
   end

   assign beat      = s_eth.tvalid && s_tready;
   assign pass_data = s_eth.tdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         hdr_valid_q    <= 1'b0;
         dest_q         <= '0;
         src_q          <= '0;
         type_q         <= '0;
         frames_passed  <= '0;
         frames_dropped <= '0;
         frames_bad     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_eth.hdr_valid) begin
                  dest_q <= s_eth.dest_mac;
                  src_q  <= s_eth.src_mac;
                  type_q <= s_eth.eth_type;
                  if (match) begin
                     state       <= HDR;
                     hdr_valid_q <= 1'b1;
                  end else begin
                     state <= DROP;
                  end
               end
            end
            HDR: begin
               if (m_eth.hdr_ready) begin
                  hdr_valid_q <= 1'b0;
                  state       <= PASS;
               end
            end
            PASS, DROP: begin
               if (beat && s_eth.tlast) begin
                  state <= IDLE;
                  if (state == PASS) frames_passed  <= frames_passed + 32'd1;
                  else               frames_dropped <= frames_dropped + 32'd1;
                  if (s_eth.tuser)   frames_bad     <= frames_bad + 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign s_eth.hdr_ready = hdr_ready;
   assign s_eth.tready    = s_tready;
   assign m_eth.hdr_valid = hdr_valid_q;
   assign m_eth.dest_mac  = dest_q;
   assign m_eth.src_mac   = src_q;
   assign m_eth.eth_type  = type_q;
   assign m_eth.tdata     = pass_data;
   assign m_eth.tvalid    = m_tvalid;
   assign m_eth.tlast     = s_eth.tlast;
   assign m_eth.tuser     = s_eth.tuser;
   assign busy            = (state != IDLE);

endmodule

// File: tb/tb_test_pattern_filter.sv
// Directed bench for test_pattern_filter: table of header/filter cases plus hand-written corner sequences.
module tb_test_pattern_filter;

   localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
   localparam logic [47:0] SRC   = 48'h0A_0B_0C_0D_0E_0F;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        accept_bcast;
   logic [47:0] local_mac;
   logic [31:0] frames_passed, frames_dropped, frames_bad;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int exp_passed  = 0;
   int exp_dropped = 0;
   int exp_bad     = 0;

   test_pattern_filter_if #(.DATA_WIDTH(8)) s_if ();
   test_pattern_filter_if #(.DATA_WIDTH(8)) m_if ();

   test_pattern_filter #(.DATA_WIDTH(8), .ETH_TYPE(16'h88B5)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .accept_bcast   (accept_bcast),
      .local_mac      (local_mac),
      .s_eth          (s_if.slave),
      .m_eth          (m_if.master),
      .frames_passed  (frames_passed),
      .frames_dropped (frames_dropped),
      .frames_bad     (frames_bad),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] dest;
      logic [15:0] etype;
      bit          en;
      bit          bc;
      int          nbeats;
      bit          exp_pass;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_passed"},  64'(frames_passed),  64'(exp_passed));
      chk({tag, "_dropped"}, 64'(frames_dropped), 64'(exp_dropped));
      chk({tag, "_bad"},     64'(frames_bad),     64'(exp_bad));
   endtask

   // Entered and left at posedge+1 with the DUT idle.
   task automatic run_frame(input logic [47:0] dest, input logic [15:0] etype, input int n,
                            input int hdr_delay, input bit toggle, input bit bad_last,
                            input bit exp_pass, input bit flip_cfg);
      int cyc, idx, rx, budget;
      logic        sv_en, sv_bc;
      logic [47:0] sv_mac;
      s_if.hdr_valid = 1'b1;
      s_if.dest_mac  = dest;
      s_if.src_mac   = SRC;
      s_if.eth_type  = etype;
      m_if.hdr_ready = 1'b0;
      #1;
      chk("idle_hdr_ready", 64'(s_if.hdr_ready), 64'd1);
      chk("idle_s_tready", 64'(s_if.tready), 64'd0);
      @(posedge clk); #1;
      s_if.hdr_valid = 1'b0;
      s_if.dest_mac  = '0;
      s_if.eth_type  = '0;
      sv_en = enable; sv_bc = accept_bcast; sv_mac = local_mac;
      if (flip_cfg) begin
         enable = 1'b0; accept_bcast = ~accept_bcast; local_mac = OTHER;
      end
      chk("busy_after_accept", 64'(busy), 64'd1);
      chk("hdr_valid_out", 64'(m_if.hdr_valid), 64'(exp_pass));
      if (exp_pass) begin
         chk("hdr_dest", 64'(m_if.dest_mac), 64'(dest));
         chk("hdr_src", 64'(m_if.src_mac), 64'(SRC));
         chk("hdr_type", 64'(m_if.eth_type), 64'(etype));
         chk("hdr_s_ready", 64'(s_if.hdr_ready), 64'd0);
         for (int k = 0; k < hdr_delay; k++) begin
            @(posedge clk); #1;
            chk("hdr_wait_valid", 64'(m_if.hdr_valid), 64'd1);
            chk("hdr_wait_dest", 64'(m_if.dest_mac), 64'(dest));
            chk("hdr_wait_type", 64'(m_if.eth_type), 64'(etype));
            chk("hdr_wait_tready", 64'(s_if.tready), 64'd0);
         end
         m_if.hdr_ready = 1'b1;
         @(posedge clk); #1;
         m_if.hdr_ready = 1'b0;
         chk("hdr_valid_cleared", 64'(m_if.hdr_valid), 64'd0);
      end
      cyc = 0; idx = 0; rx = 0; budget = 4 * n + 20;
      while (idx < n && cyc < budget) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = idx[7:0];
         s_if.tlast  = (idx == n - 1);
         s_if.tuser  = bad_last && (idx == n - 1);
         m_if.tready = toggle ? ~cyc[0] : 1'b1;
         #1;
         if (exp_pass) begin
            if (m_if.tvalid && m_if.tready) begin
               chk("pass_data", 64'(m_if.tdata), 64'(rx[7:0]));
               chk("pass_tlast", 64'(m_if.tlast), 64'(rx == n - 1));
               chk("pass_tuser", 64'(m_if.tuser), 64'(bad_last && rx == n - 1));
               rx++;
            end
         end else begin
            chk("drop_m_tvalid", 64'(m_if.tvalid), 64'd0);
            chk("drop_s_tready", 64'(s_if.tready), 64'd1);
         end
         if (s_if.tvalid && s_if.tready) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
      m_if.tready = 1'b1;
      if (idx < n) chk("frame_timeout", 64'(idx), 64'(n));
      if (exp_pass) chk("pass_beats", 64'(rx), 64'(n));
      else          chk("drop_cycles", 64'(cyc), 64'(n));
      chk("idle_after_last", 64'(busy), 64'd0);
      chk("idle_hdr_ready_again", 64'(s_if.hdr_ready), 64'd1);
      if (exp_pass) exp_passed++; else exp_dropped++;
      if (bad_last) exp_bad++;
      chk_counters("frame");
      enable = sv_en; accept_bcast = sv_bc; local_mac = sv_mac;
   endtask

   initial begin
      vecs[0] = '{LOCAL, 16'h88B5, 1'b1, 1'b0, 64, 1'b1};
      vecs[1] = '{LOCAL, 16'h0800, 1'b1, 1'b0, 64, 1'b0};
      vecs[2] = '{BCAST, 16'h88B5, 1'b1, 1'b0, 4,  1'b0};
      vecs[3] = '{BCAST, 16'h88B5, 1'b1, 1'b1, 4,  1'b1};
      vecs[4] = '{LOCAL, 16'h88B5, 1'b0, 1'b1, 4,  1'b0};
      vecs[5] = '{OTHER, 16'h88B5, 1'b1, 1'b1, 4,  1'b0};
      vecs[6] = '{LOCAL, 16'h88B5, 1'b1, 1'b0, 1,  1'b1};
      vecs[7] = '{LOCAL, 16'h0800, 1'b1, 1'b0, 1,  1'b0};

      rst = 1'b1; enable = 1'b1; accept_bcast = 1'b0; local_mac = LOCAL;
      s_if.hdr_valid = 1'b0; s_if.dest_mac = '0; s_if.src_mac = '0; s_if.eth_type = '0;
      s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
      m_if.hdr_ready = 1'b0; m_if.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hdr_ready", 64'(s_if.hdr_ready), 64'd1);
      chk("rst_m_hdr_valid", 64'(m_if.hdr_valid), 64'd0);
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("rst_m_dest", 64'(m_if.dest_mac), 64'd0);
      chk_counters("rst");

      foreach (vecs[i]) begin
         enable       = vecs[i].en;
         accept_bcast = vecs[i].bc;
         run_frame(vecs[i].dest, vecs[i].etype, vecs[i].nbeats, 0, 1'b0, 1'b0, vecs[i].exp_pass, 1'b0);
      end
      enable = 1'b1; accept_bcast = 1'b0;

      // Header held off for 5 cycles, downstream ready alternating.
      run_frame(LOCAL, 16'h88B5, 64, 5, 1'b1, 1'b0, 1'b1, 1'b0);
      // Errored last beat on a passed frame, with filter settings disturbed mid-frame.
      run_frame(LOCAL, 16'h88B5, 8, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      // Errored last beat on a dropped frame.
      run_frame(LOCAL, 16'h0800, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset asserted in the middle of a passing frame.
      s_if.hdr_valid = 1'b1; s_if.dest_mac = LOCAL; s_if.src_mac = SRC; s_if.eth_type = 16'h88B5;
      @(posedge clk); #1;
      s_if.hdr_valid = 1'b0;
      m_if.hdr_ready = 1'b1;
      @(posedge clk); #1;
      m_if.hdr_ready = 1'b0;
      for (int b = 0; b < 20; b++) begin
         s_if.tvalid = 1'b1; s_if.tdata = 8'(b); s_if.tlast = 1'b0;
         @(posedge clk); #1;
      end
      chk("mid_frame_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      s_if.tvalid = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hdr_ready", 64'(s_if.hdr_ready), 64'd1);
      chk("midrst_m_hdr_valid", 64'(m_if.hdr_valid), 64'd0);
      chk("midrst_m_dest", 64'(m_if.dest_mac), 64'd0);
      chk("midrst_m_type", 64'(m_if.eth_type), 64'd0);
      exp_passed = 0; exp_dropped = 0; exp_bad = 0;
      chk_counters("midrst");
      run_frame(LOCAL, 16'h88B5, 16, 0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
